sqrt_radix4_prenorm: RTL and testbench

- Input front end of the radix-4 hyperbolic CORDIC square-root pipeline.
- Takes an unsigned integer operand and normalises it by an even left shift, so the mantissa m lies in [1/4, 1).
- Forms the starting vector for the first monotone rotation stage: X = m + 1/4, Y = m - 1/4, start rotation index, unity gain.
- Emits the half-exponent, so that sqrt(a) = sqrt(m) * 2^half_exp; a valid/ready handshake provides backpressure.

---
 rtl/sqrt_radix4_prenorm.sv | 108 ++++++++++
 tb/tb_sqrt_radix4_prenorm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_radix4_prenorm.sv
// Front end of the radix-4 hyperbolic CORDIC square root: even-shift normalisation of
// an unsigned operand to m in [1/4,1) and formation of the start vector (m+1/4, m-1/4).
module sqrt_radix4_prenorm #(
  parameter int DSIZE = 17,
  parameter int ISIZE = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ISIZE-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] OX,
  output logic [DSIZE-1:0] OY,
  output logic [5:0]       rotation,
  output logic [DSIZE-1:0] K,
  output logic [5:0]       half_exp,
  output logic             zero
);

  localparam int LZW = $clog2(ISIZE + 1);
  localparam int MW  = DSIZE - 1;
  localparam logic [DSIZE-1:0] QUARTER = DSIZE'(1) << (DSIZE - 3);
  localparam logic [DSIZE-1:0] ONE     = DSIZE'(1) << (DSIZE - 1);

  logic             s1_valid;
  logic [ISIZE-1:0] s1_data;
  logic [LZW-1:0]   s1_lz;

  logic             s1_adv;
  logic             s2_adv;
  logic [LZW-1:0]   lz_next;

  logic [LZW-1:0]   shift;
  logic [MW-1:0]    m_fix;
  logic [LZW-1:0]   he_wide;
  logic [DSIZE-1:0] ox_next;
  logic [DSIZE-1:0] oy_next;
  logic [5:0]       he_next;
  logic             zero_next;

  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign s1_adv   = in_valid & in_ready;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lz_next = LZW'(ISIZE);
    for (int i = 0; i < ISIZE; i++) begin
      if (in_data[i]) begin
        lz_next = LZW'(ISIZE - 1 - i);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_lz    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_lz    <= lz_next;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // A zero operand shifts by ISIZE, giving m_fix=0 and half_exp=0 with no special case.
  always_comb begin
    shift     = {s1_lz[LZW-1:1], 1'b0};
    m_fix     = MW'((s1_data << shift) >> (ISIZE - MW));
    ox_next   = {1'b0, m_fix} + QUARTER;
    oy_next   = {1'b0, m_fix} - QUARTER;
    he_wide   = (LZW'(ISIZE) - shift) >> 1;
    he_next   = 6'(he_wide);
    zero_next = (s1_lz == LZW'(ISIZE));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      OX        <= '0;
      OY        <= '0;
      rotation  <= '0;
      K         <= '0;
      half_exp  <= '0;
      zero      <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= 1'b1;
        OX        <= ox_next;
        OY        <= oy_next;
        rotation  <= 6'd1;
        K         <= ONE;
        half_exp  <= he_next;
        zero      <= zero_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_radix4_prenorm.sv
// Self-checking bench for sqrt_radix4_prenorm: scoreboard against an arithmetic model,
// directed literal cases, backpressure, asynchronous reset and random traffic.
module tb_sqrt_radix4_prenorm;

  typedef struct packed {
    logic [16:0] ox;
    logic [16:0] oy;
    logic [5:0]  he;
    logic        z;
    logic [5:0]  rot;
    logic [16:0] k;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    vec_t        v;
  } ent_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] OX;
  logic [16:0] OY;
  logic [5:0]  rotation;
  logic [16:0] K;
  logic [5:0]  half_exp;
  logic        zero;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  ent_t exp_q[$];
  logic accepted;
  logic blocked;
  logic held_valid = 1'b0;
  vec_t held_vec;
  vec_t dut_vec;

  sqrt_radix4_prenorm #(.DSIZE(17), .ISIZE(32)) dut (
    .clock(clock), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .OX(OX), .OY(OY), .rotation(rotation), .K(K),
    .half_exp(half_exp), .zero(zero)
  );

  always #5 clock = ~clock;

  assign dut_vec = {OX, OY, half_exp, zero, rotation, K};

  // a = m * 4^k with m in [1/4,1): k is the smallest power with a < 4^k.
  function automatic vec_t model(input logic [31:0] a);
    vec_t r;
    longint unsigned aa;
    longint unsigned mf;
    int k;
    aa = 64'(a);
    r.rot = 6'd1;
    r.k = 17'd65536;
    if (a == 32'd0) begin
      r.ox = 17'd16384;
      r.oy = 17'h1C000;
      r.he = 6'd0;
      r.z = 1'b1;
    end else begin
      k = 0;
      while (aa >= (64'd1 << (2 * k))) k++;
      mf = (aa << 16) >> (2 * k);
      r.ox = 17'(mf + 64'd16384);
      r.oy = 17'(mf - 64'd16384);
      r.he = 6'(k);
      r.z = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    if ($urandom_range(0, 9) == 0) return 32'd0;
    return $urandom >> $urandom_range(0, 31);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive after the edge, sample the handshake mid-cycle, return just after the next edge.
  task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clock);
    accepted = in_valid && in_ready;
    blocked  = in_valid && !in_ready;
    @(posedge clock);
    #1;
  endtask

  always @(negedge rst_n) begin
    exp_q.delete();
    held_valid = 1'b0;
  end

  // Single compare process: hold stability, in-order results, and the mantissa bound.
  always @(negedge clock) begin
    if (rst_n) begin
      if (held_valid) begin
        check_output("stall_valid", {63'd0, out_valid}, 64'd1);
        check_output("stall_hold", dut_vec, held_vec);
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_out: got %h, expected no output", dut_vec);
        end else begin
          ent_t e;
          longint unsigned lhs, rhs, mfix, sc;
          e = exp_q.pop_front();
          check_output("result", dut_vec, e.v);
          if (e.a != 32'd0) begin
            mfix = 64'(17'(OX - 17'd16384));
            sc   = 64'(e.a) << 16;
            lhs  = mfix << (2 * half_exp);
            rhs  = (mfix + 64'd1) << (2 * half_exp);
            check_output("mant_bound", {63'd0, (lhs <= sc) && (sc < rhs)}, 64'd1);
          end
        end
      end
      held_valid = out_valid && !out_ready;
      held_vec   = dut_vec;
      if (in_valid && in_ready) exp_q.push_back('{a: in_data, v: model(in_data)});
    end
  end

  task automatic directed(input logic [31:0] a, input vec_t lit);
    check_output("model_pin", model(a), lit);
    apply_stimulus(1'b1, a, 1'b1);
    check_output("lat_not_yet", {63'd0, out_valid}, 64'd0);
    apply_stimulus(1'b0, 32'd0, 1'b1);
    check_output("lat_valid", {63'd0, out_valid}, 64'd1);
    check_output("lit_vec", dut_vec, lit);
    apply_stimulus(1'b0, 32'd0, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 50)) begin
      apply_stimulus(1'b0, 32'd0, 1'b1);
      n++;
    end
    check_output(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #3000000;
    n_bad++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int next_op;
    int pops0;
    logic saw_block;

    repeat (3) @(posedge clock);
    #1;
    check_output("rst_outs", {dut_vec, out_valid}, 65'd0);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    check_output("rst_ready", {63'd0, in_ready}, 64'd1);
    check_output("rst_valid", {63'd0, out_valid}, 64'd0);

    directed(32'd1,          '{ox: 17'd32768, oy: 17'd0,     he: 6'd1,  z: 1'b0, rot: 6'd1, k: 17'd65536});
    directed(32'd2,          '{ox: 17'd49152, oy: 17'd16384, he: 6'd1,  z: 1'b0, rot: 6'd1, k: 17'd65536});
    directed(32'hFFFF_FFFF,  '{ox: 17'd81919, oy: 17'd49151, he: 6'd16, z: 1'b0, rot: 6'd1, k: 17'd65536});
    directed(32'd0,          '{ox: 17'd16384, oy: 17'h1C000, he: 6'd0,  z: 1'b1, rot: 6'd1, k: 17'd65536});
    directed(32'd4,          '{ox: 17'd32768, oy: 17'd0,     he: 6'd2,  z: 1'b0, rot: 6'd1, k: 17'd65536});

    // Streaming a=1..5 with out_ready low on cycles 3-6.
    next_op = 1;
    saw_block = 1'b0;
    pops0 = n_pop;
    for (int c = 0; c < 20; c++) begin
      if (next_op <= 5) begin
        apply_stimulus(1'b1, 32'(next_op), !(c >= 3 && c <= 6));
        if (accepted) next_op++;
        if (blocked) saw_block = 1'b1;
      end else begin
        apply_stimulus(1'b0, 32'd0, !(c >= 3 && c <= 6));
      end
    end
    check_output("stream_block", {63'd0, saw_block}, 64'd1);
    check_output("stream_pushed", 64'(next_op), 64'd6);
    drain("stream_drain");
    check_output("stream_count", 64'(n_pop - pops0), 64'd5);

    // Asynchronous reset with two operands in flight.
    apply_stimulus(1'b1, 32'd11, 1'b0);
    apply_stimulus(1'b1, 32'd22, 1'b0);
    in_valid = 1'b0;
    check_output("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst", {dut_vec, out_valid}, 65'd0);
    check_output("async_rst_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clock);
    #1 rst_n = 1'b1;
    check_output("post_rst_ready", {63'd0, in_ready}, 64'd1);
    for (int c = 0; c < 6; c++) begin
      apply_stimulus(1'b0, 32'd0, 1'b1);
      check_output("no_stale", {63'd0, out_valid}, 64'd0);
    end

    // Back-to-back random operands at full rate.
    pops0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(1'b1, rand_op(), 1'b1);
      check_output("thru_accept", {63'd0, accepted}, 64'd1);
    end
    drain("thru_drain");
    check_output("thru_count", 64'(n_pop - pops0), 64'd100);

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 2) != 0);
    end
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
